// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: default width,
// skid-buffer state encoding and a width helper for the beat counter.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_t;

    // Ceiling log2, clamped to at least 1 so a 1-beat packet still gets a counter bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry skid buffer: captures the word returned by the previous pop and
// presents the oldest stored word at the head until the consumer drains it.
module skid_buf_2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             drain,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    skid_state_t      state_reg, state_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] tail_reg, tail_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        unique case (state_reg)
            S_EMPTY: begin
                if (wr_en) begin
                    head_next  = wr_data;
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (wr_en && drain) begin
                    head_next = wr_data;
                end else if (wr_en) begin
                    tail_next  = wr_data;
                    state_next = S_TWO;
                end else if (drain) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                // The pop gate upstream guarantees no capture arrives here without a drain.
                if (drain) begin
                    head_next = tail_reg;
                    if (wr_en) begin
                        tail_next = wr_data;
                    end else begin
                        state_next = S_ONE;
                    end
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    assign occ   = state_reg;
    assign head  = head_reg;
    assign valid = (state_reg != S_EMPTY);

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain consumer of the dual-clock FIFO: pops words into a skid buffer,
// streams them out valid/ready with fixed-length framing, counts pops, latches errors.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int PKT_LEN   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 fifo_rd_error,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int                BEAT_W    = clog2_min1(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic                 inflight_reg;
    logic [BEAT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [CNT_WIDTH-1:0] word_cnt_reg;
    logic                 err_reg;
    logic                 drain;
    logic [1:0]           occ;
    logic [2:0]           commit;

    assign drain = m_valid & m_ready;

    // Words already owed to the buffer after this edge; pop only if one slot stays free.
    assign commit     = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, drain};
    assign fifo_rd_en = !rst && !fifo_empty && (commit < 3'd2);

    skid_buf_2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk    (rd_clk),
        .rst    (rst),
        .wr_en  (inflight_reg),
        .wr_data(fifo_rdata),
        .drain  (drain),
        .occ    (occ),
        .head   (m_data),
        .valid  (m_valid)
    );

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (drain) begin
            beat_cnt_next = (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight_reg <= 1'b0;
            beat_cnt_reg <= '0;
            word_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd_en;
            beat_cnt_reg <= beat_cnt_next;
            if (fifo_rd_en) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            if (fifo_rd_error) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign m_last   = m_valid & (beat_cnt_reg == LAST_BEAT);
    assign err      = err_reg;
    assign word_cnt = word_cnt_reg;

endmodule
